// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Single-word instruction memory handshake between the fetch stage and memory.
//   imem_req   : fetch request, held high until imem_ack
//   imem_addr  : fetch address, valid while imem_req is high
//   imem_rdata : instruction word, valid only when imem_ack is high
//   imem_ack   : memory response, may arrive in the same cycle as imem_req
// Modports: master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 8
);
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               imem_ack;

   modport master (output imem_req, imem_addr, input imem_rdata, imem_ack);
   modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ack);
endinterface

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch / sequencing stage. Holds the PC, fetches one word per
// request over the bus handshake, latches it into the instruction register and
// presents op/ra/rb to the control unit. Stalls on back-pressure and redirects
// the PC for branches/jumps resolved downstream.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus (master)      : instruction memory handshake (instr_fetch_if)
//   stall             : downstream not ready, freezes current instruction
//   redirect          : taken branch/jump strobe
//   redirect_pc       : redirect target, valid with redirect
//   op, ra, rb        : opcode and register fields of ir
//   instr_valid       : op/ra/rb hold a live instruction
//   pc                : address of the instruction currently in ir
//   fetch_err         : sticky ack-watchdog error (IF_TIMEOUT_EN only)
//
// Build option IF_TIMEOUT_EN: adds an ack watchdog. After TIMEOUT request
// cycles without ack, fetch_err is set, imem_req drops for one cycle and the
// same pc is re-requested.
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter int              OP      = 4,
   parameter int              INSTR_W = 8,
   parameter int              PC_W    = 8,
   parameter logic [PC_W-1:0] RST_PC  = '0
`ifdef IF_TIMEOUT_EN
   ,
   parameter int              TIMEOUT = 16
`endif
) (
   input  logic               clk,
   input  logic               rst,
   instr_fetch_if.master      bus,
   input  logic               stall,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic [OP-1:0]      op,
   output logic [1:0]         ra,
   output logic [1:0]         rb,
   output logic               instr_valid,
   output logic [PC_W-1:0]    pc
`ifdef IF_TIMEOUT_EN
   ,
   output logic               fetch_err
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

   state_t             state, state_nxt;
   logic [PC_W-1:0]    pc_q, pc_nxt;
   logic [PC_W-1:0]    pend_pc, pend_pc_nxt;
   logic               redir_pend, redir_pend_nxt;
   logic [INSTR_W-1:0] ir, ir_nxt;
   logic               vld, vld_nxt;
   logic               req_on;
   logic               ack;

`ifdef IF_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
   logic               backoff, backoff_nxt;
   logic               err_q, err_nxt;

   // Request is purely a function of registered state: no path from ack/stall.
   assign req_on    = (state == REQ) && !backoff;
   assign fetch_err = err_q;
`else
   assign req_on    = (state == REQ);
`endif

   assign bus.imem_req  = req_on;
   assign bus.imem_addr = pc_q;
   // An ack is only meaningful while we are actually requesting.
   assign ack           = bus.imem_ack & req_on;

   assign op          = ir[INSTR_W-1 -: OP];
   assign ra          = ir[3:2];
   assign rb          = ir[1:0];
   assign instr_valid = vld;
   assign pc          = pc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pc_q       <= RST_PC;
         pend_pc    <= '0;
         redir_pend <= 1'b0;
         ir         <= '0;
         vld        <= 1'b0;
`ifdef IF_TIMEOUT_EN
         wait_cnt   <= '0;
         backoff    <= 1'b0;
         err_q      <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         pc_q       <= pc_nxt;
         pend_pc    <= pend_pc_nxt;
         redir_pend <= redir_pend_nxt;
         ir         <= ir_nxt;
         vld        <= vld_nxt;
`ifdef IF_TIMEOUT_EN
         wait_cnt   <= wait_cnt_nxt;
         backoff    <= backoff_nxt;
         err_q      <= err_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc_q;
      pend_pc_nxt    = pend_pc;
      redir_pend_nxt = redir_pend;
      ir_nxt         = ir;
      vld_nxt        = vld;
`ifdef IF_TIMEOUT_EN
      wait_cnt_nxt   = wait_cnt;
      backoff_nxt    = backoff;
      err_nxt        = err_q;
`endif
      case (state)
         IDLE: begin
            state_nxt = REQ;
`ifdef IF_TIMEOUT_EN
            wait_cnt_nxt = '0;
`endif
         end
         REQ: begin
            if (ack) begin
`ifdef IF_TIMEOUT_EN
               wait_cnt_nxt = '0;
`endif
               if (redirect) begin
                  // Same-cycle redirect beats both the data and any pending target.
                  pc_nxt         = redirect_pc;
                  redir_pend_nxt = 1'b0;
               end else if (redir_pend) begin
                  // Word belongs to the wrong path: drop it and refetch the target.
                  pc_nxt         = pend_pc;
                  redir_pend_nxt = 1'b0;
               end else begin
                  ir_nxt    = bus.imem_rdata;
                  vld_nxt   = 1'b1;
                  state_nxt = HOLD;
               end
            end else begin
               // The outstanding request cannot be withdrawn; remember the target.
               if (redirect) begin
                  pend_pc_nxt    = redirect_pc;
                  redir_pend_nxt = 1'b1;
               end
`ifdef IF_TIMEOUT_EN
               if (backoff) begin
                  backoff_nxt = 1'b0;
               end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                  err_nxt      = 1'b1;
                  backoff_nxt  = 1'b1;
                  wait_cnt_nxt = '0;
               end else begin
                  wait_cnt_nxt = wait_cnt + CNT_W'(1);
               end
`endif
            end
         end
         HOLD: begin
            // While stalled, redirect is ignored (downstream must not send one).
            if (!stall) begin
               pc_nxt    = redirect ? redirect_pc : pc_q + PC_W'(1);
               vld_nxt   = 1'b0;
               state_nxt = REQ;
`ifdef IF_TIMEOUT_EN
               wait_cnt_nxt = '0;
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed self-checking bench for instr_fetch. Inputs are driven and outputs
// sampled on the falling edge; each task covers one scenario and continues
// from the state the previous task left behind.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
   logic       clk = 1'b0;
   logic       rst;
   logic       stall;
   logic       redirect;
   logic [7:0] redirect_pc;
   logic [3:0] op;
   logic [1:0] ra, rb;
   logic       instr_valid;
   logic [7:0] pc;
`ifdef IF_TIMEOUT_EN
   logic       fetch_err;
`endif
   int pass_cnt  = 0;
   int total_cnt = 0;

   instr_fetch_if #(.PC_W(8), .INSTR_W(8)) ifc ();

   instr_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (ifc.master),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .op          (op),
      .ra          (ra),
      .rb          (rb),
      .instr_valid (instr_valid),
      .pc          (pc)
`ifdef IF_TIMEOUT_EN
      ,
      .fetch_err   (fetch_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      total_cnt++; if (ifc.imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", ifc.imem_req); else pass_cnt++;
      total_cnt++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", instr_valid); else pass_cnt++;
      total_cnt++; if (pc !== 8'h00) $display("FAIL reset_pc got %h want 00", pc); else pass_cnt++;
      total_cnt++; if ({op, ra, rb} !== 8'h00) $display("FAIL reset_ir got %h want 00", {op, ra, rb}); else pass_cnt++;
`ifdef IF_TIMEOUT_EN
      total_cnt++; if (fetch_err !== 1'b0) $display("FAIL reset_err got %b want 0", fetch_err); else pass_cnt++;
`endif
      rst = 1'b0;
   endtask

   task automatic test_zero_wait();
      step();
      total_cnt++; if ({ifc.imem_req, ifc.imem_addr} !== {1'b1, 8'h00}) $display("FAIL zw_req got %b/%h want 1/00", ifc.imem_req, ifc.imem_addr); else pass_cnt++;
      ifc.imem_ack = 1'b1; ifc.imem_rdata = 8'h5A;
      step();
      ifc.imem_ack = 1'b0;
      total_cnt++; if (instr_valid !== 1'b1) $display("FAIL zw_valid got %b want 1", instr_valid); else pass_cnt++;
      total_cnt++; if ({op, ra, rb} !== {4'h5, 2'd2, 2'd2}) $display("FAIL zw_fields got %h/%0d/%0d want 5/2/2", op, ra, rb); else pass_cnt++;
      total_cnt++; if (pc !== 8'h00) $display("FAIL zw_pc got %h want 00", pc); else pass_cnt++;
      total_cnt++; if (ifc.imem_req !== 1'b0) $display("FAIL zw_hold_req got %b want 0", ifc.imem_req); else pass_cnt++;
   endtask

   task automatic test_delayed_ack();
      step();  // HOLD -> REQ at pc 0x01
      for (int i = 0; i < 3; i++) begin
         total_cnt++; if ({ifc.imem_req, ifc.imem_addr, instr_valid} !== {1'b1, 8'h01, 1'b0}) $display("FAIL dly_wait%0d got %b/%h/%b want 1/01/0", i, ifc.imem_req, ifc.imem_addr, instr_valid); else pass_cnt++;
         step();
      end
      total_cnt++; if ({ifc.imem_req, ifc.imem_addr} !== {1'b1, 8'h01}) $display("FAIL dly_ackcyc got %b/%h want 1/01", ifc.imem_req, ifc.imem_addr); else pass_cnt++;
      ifc.imem_ack = 1'b1; ifc.imem_rdata = 8'h31;
      step();
      ifc.imem_ack = 1'b0;
      total_cnt++; if ({instr_valid, op, pc} !== {1'b1, 4'h3, 8'h01}) $display("FAIL dly_done got %b/%h/%h want 1/3/01", instr_valid, op, pc); else pass_cnt++;
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         total_cnt++; if ({instr_valid, op, pc, ifc.imem_req} !== {1'b1, 4'h3, 8'h01, 1'b0}) $display("FAIL stall%0d got %b/%h/%h/%b want 1/3/01/0", i, instr_valid, op, pc, ifc.imem_req); else pass_cnt++;
      end
      stall = 1'b0;
      step();
      total_cnt++; if ({ifc.imem_req, ifc.imem_addr, instr_valid} !== {1'b1, 8'h02, 1'b0}) $display("FAIL stall_release got %b/%h/%b want 1/02/0", ifc.imem_req, ifc.imem_addr, instr_valid); else pass_cnt++;
   endtask

   task automatic test_redirect_hold();
      ifc.imem_ack = 1'b1; ifc.imem_rdata = 8'h10;
      step();
      ifc.imem_ack = 1'b0;
      redirect = 1'b1; redirect_pc = 8'h40;
      step();
      redirect = 1'b0;
      total_cnt++; if ({ifc.imem_req, ifc.imem_addr} !== {1'b1, 8'h40}) $display("FAIL redir_hold got %b/%h want 1/40", ifc.imem_req, ifc.imem_addr); else pass_cnt++;
   endtask

   task automatic test_redirect_pending();
      ifc.imem_ack = 1'b1; ifc.imem_rdata = 8'h10;
      step();
      ifc.imem_ack = 1'b0;
      redirect = 1'b1; redirect_pc = 8'h07;
      step();
      total_cnt++; if (ifc.imem_addr !== 8'h07) $display("FAIL pend_start got %h want 07", ifc.imem_addr); else pass_cnt++;
      redirect_pc = 8'h30;
      step();
      redirect_pc = 8'h20;  // overwrites the pending 0x30
      step();
      redirect = 1'b0;
      total_cnt++; if ({ifc.imem_req, ifc.imem_addr} !== {1'b1, 8'h07}) $display("FAIL pend_addr_stable got %b/%h want 1/07", ifc.imem_req, ifc.imem_addr); else pass_cnt++;
      ifc.imem_ack = 1'b1; ifc.imem_rdata = 8'hEE;
      step();
      ifc.imem_ack = 1'b0;
      total_cnt++; if ({ifc.imem_req, ifc.imem_addr, instr_valid} !== {1'b1, 8'h20, 1'b0}) $display("FAIL pend_discard got %b/%h/%b want 1/20/0", ifc.imem_req, ifc.imem_addr, instr_valid); else pass_cnt++;
      ifc.imem_ack = 1'b1; ifc.imem_rdata = 8'h9B;
      step();
      ifc.imem_ack = 1'b0;
      total_cnt++; if ({instr_valid, op, ra, rb, pc} !== {1'b1, 4'h9, 2'd2, 2'd3, 8'h20}) $display("FAIL pend_target got %b/%h/%0d/%0d/%h want 1/9/2/3/20", instr_valid, op, ra, rb, pc); else pass_cnt++;
   endtask

   task automatic test_redirect_with_ack();
      step();  // REQ at 0x21
      ifc.imem_ack = 1'b1; ifc.imem_rdata = 8'h77;
      redirect = 1'b1; redirect_pc = 8'h60;
      step();
      ifc.imem_ack = 1'b0; redirect = 1'b0;
      total_cnt++; if ({ifc.imem_req, ifc.imem_addr, instr_valid} !== {1'b1, 8'h60, 1'b0}) $display("FAIL redir_ack got %b/%h/%b want 1/60/0", ifc.imem_req, ifc.imem_addr, instr_valid); else pass_cnt++;
      ifc.imem_ack = 1'b1; ifc.imem_rdata = 8'h44;
      step();
      ifc.imem_ack = 1'b0;
      total_cnt++; if ({instr_valid, op, pc} !== {1'b1, 4'h4, 8'h60}) $display("FAIL redir_ack_fetch got %b/%h/%h want 1/4/60", instr_valid, op, pc); else pass_cnt++;
   endtask

   task automatic test_wrap();
      redirect = 1'b1; redirect_pc = 8'hFF;
      step();
      redirect = 1'b0;
      ifc.imem_ack = 1'b1; ifc.imem_rdata = 8'h12;
      step();
      ifc.imem_ack = 1'b0;
      total_cnt++; if ({instr_valid, pc} !== {1'b1, 8'hFF}) $display("FAIL wrap_hold got %b/%h want 1/ff", instr_valid, pc); else pass_cnt++;
      step();
      total_cnt++; if ({ifc.imem_req, ifc.imem_addr} !== {1'b1, 8'h00}) $display("FAIL wrap_addr got %b/%h want 1/00", ifc.imem_req, ifc.imem_addr); else pass_cnt++;
   endtask

   task automatic test_reset_mid_req();
      rst = 1'b1; ifc.imem_ack = 1'b1; ifc.imem_rdata = 8'hAB;
      step();
      rst = 1'b0; ifc.imem_ack = 1'b0;
      total_cnt++; if ({instr_valid, ifc.imem_req, pc, op, ra, rb} !== {1'b0, 1'b0, 8'h00, 8'h00}) $display("FAIL rst_mid got %b/%b/%h/%h want 0/0/00/00", instr_valid, ifc.imem_req, pc, {op, ra, rb}); else pass_cnt++;
      step();
      total_cnt++; if ({ifc.imem_req, ifc.imem_addr} !== {1'b1, 8'h00}) $display("FAIL rst_restart got %b/%h want 1/00", ifc.imem_req, ifc.imem_addr); else pass_cnt++;
   endtask

`ifdef IF_TIMEOUT_EN
   task automatic test_timeout();
      for (int i = 0; i < 16; i++) begin
         total_cnt++; if ({ifc.imem_req, fetch_err} !== {1'b1, 1'b0}) $display("FAIL to_wait%0d got %b/%b want 1/0", i, ifc.imem_req, fetch_err); else pass_cnt++;
         step();
      end
      total_cnt++; if ({ifc.imem_req, fetch_err} !== {1'b0, 1'b1}) $display("FAIL to_expire got %b/%b want 0/1", ifc.imem_req, fetch_err); else pass_cnt++;
      step();
      total_cnt++; if ({ifc.imem_req, ifc.imem_addr, fetch_err} !== {1'b1, 8'h00, 1'b1}) $display("FAIL to_retry got %b/%h/%b want 1/00/1", ifc.imem_req, ifc.imem_addr, fetch_err); else pass_cnt++;
   endtask
`endif

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
      ifc.imem_ack = 1'b0; ifc.imem_rdata = 8'h00;
      @(negedge clk);
      test_reset();
      test_zero_wait();
      test_delayed_ack();
      test_stall();
      test_redirect_hold();
      test_redirect_pending();
      test_redirect_with_ack();
      test_wrap();
      test_reset_mid_req();
`ifdef IF_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", pass_cnt, total_cnt);
      $fatal(1);
   end
endmodule
